// File: rtl/pd_id_queue_if.sv
// Handshake bundle between the predecode stage, the PD/ID queue and the decode stage.
interface pd_id_queue_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 3
);
  logic              pd_valid;
  logic              pd_ready;
  logic [PC_W-1:0]   pd_pc;
  logic [INST_W-1:0] pd_inst;
  logic              pd_bd;
  logic              pd_jump;
  logic              id_stall;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_bd;
  logic              id_jump;
  logic [CNT_W-1:0]  count;

  modport master (
    output pd_valid, pd_pc, pd_inst, pd_bd, pd_jump, id_stall,
    input  pd_ready, id_valid, id_pc, id_inst, id_bd, id_jump, count
  );

  modport slave (
    input  pd_valid, pd_pc, pd_inst, pd_bd, pd_jump, id_stall,
    output pd_ready, id_valid, id_pc, id_inst, id_bd, id_jump, count
  );
endinterface

// File: rtl/pd_id_queue.sv
// DEPTH-entry instruction FIFO between predecode and decode, flushed on refresh,
// optionally holding a jump back until its delay slot is queued behind it.
module pd_id_queue #(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter int INST_W    = 32,
  parameter int PAIR_JUMP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refresh,
  pd_id_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_EMPTY = {CW{1'b0}};

  logic [PC_W-1:0]   pc_mem_r   [DEPTH];
  logic [INST_W-1:0] inst_mem_r [DEPTH];
  logic              bd_mem_r   [DEPTH];
  logic              jump_mem_r [DEPTH];

  logic [AW-1:0] rptr_r;
  logic [AW-1:0] wptr_r;
  logic [CW-1:0] count_r;

  logic              pd_ready_s;
  logic              head_ok_s;
  logic              push_s;
  logic              pop_s;
  logic [PC_W-1:0]   id_pc_s;
  logic [INST_W-1:0] id_inst_s;
  logic              id_bd_s;
  logic              id_jump_s;

  // Pop does not free space this cycle, so readiness depends on registered count alone.
  assign pd_ready_s = (count_r != CNT_FULL);

  // Head qualification, including holding a lone jump until its delay slot arrives.
  always_comb begin
    head_ok_s = 1'b0;
    if (count_r == CNT_EMPTY) begin
      head_ok_s = 1'b0;
    end else if (PAIR_JUMP != 0 && jump_mem_r[rptr_r] && count_r < CNT_TWO) begin
      head_ok_s = 1'b0;
    end else begin
      head_ok_s = 1'b1;
    end
  end

  assign push_s = bus.pd_valid & pd_ready_s & ~refresh;
  assign pop_s  = head_ok_s & ~bus.id_stall & ~refresh;

  // Head data presented to ID, forced to zero while nothing is offered.
  always_comb begin
    id_pc_s   = {PC_W{1'b0}};
    id_inst_s = {INST_W{1'b0}};
    id_bd_s   = 1'b0;
    id_jump_s = 1'b0;
    if (head_ok_s) begin
      id_pc_s   = pc_mem_r[rptr_r];
      id_inst_s = inst_mem_r[rptr_r];
      id_bd_s   = bd_mem_r[rptr_r];
      id_jump_s = jump_mem_r[rptr_r];
    end else begin
      id_pc_s   = {PC_W{1'b0}};
      id_inst_s = {INST_W{1'b0}};
      id_bd_s   = 1'b0;
      id_jump_s = 1'b0;
    end
  end

  // Pointer and occupancy state; reset wins over refresh, refresh wins over traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_r  <= {AW{1'b0}};
      wptr_r  <= {AW{1'b0}};
      count_r <= CNT_EMPTY;
    end else if (refresh) begin
      rptr_r  <= {AW{1'b0}};
      wptr_r  <= {AW{1'b0}};
      count_r <= CNT_EMPTY;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end else begin
        rptr_r <= rptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; refresh leaves contents stale since outputs are masked by count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= {PC_W{1'b0}};
        inst_mem_r[i] <= {INST_W{1'b0}};
        bd_mem_r[i]   <= 1'b0;
        jump_mem_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      pc_mem_r[wptr_r]   <= bus.pd_pc;
      inst_mem_r[wptr_r] <= bus.pd_inst;
      bd_mem_r[wptr_r]   <= bus.pd_bd;
      jump_mem_r[wptr_r] <= bus.pd_jump;
    end else begin
      pc_mem_r[wptr_r]   <= pc_mem_r[wptr_r];
      inst_mem_r[wptr_r] <= inst_mem_r[wptr_r];
      bd_mem_r[wptr_r]   <= bd_mem_r[wptr_r];
      jump_mem_r[wptr_r] <= jump_mem_r[wptr_r];
    end
  end

  assign bus.pd_ready = pd_ready_s;
  assign bus.id_valid = head_ok_s;
  assign bus.id_pc    = id_pc_s;
  assign bus.id_inst  = id_inst_s;
  assign bus.id_bd    = id_bd_s;
  assign bus.id_jump  = id_jump_s;
  assign bus.count    = count_r;
endmodule

// File: tb/tb_pd_id_queue.sv
// Directed checks of the PD/ID queue: reset, fill/drain, wrap, jump pairing, refresh, full.
module tb_pd_id_queue;
  logic clk;
  logic reset;
  logic refresh;
  int   n_checks;
  int   n_fail;

  pd_id_queue_if #(.PC_W(32), .INST_W(32), .CNT_W(3)) bus ();

  pd_id_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .PAIR_JUMP(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .refresh (refresh),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    bus.pd_valid = 1'b1;
    bus.pd_pc    = pc;
    bus.pd_inst  = pc ^ 32'hA5A5_0000;
    tick();
    bus.pd_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    refresh = 1'b0;
    bus.pd_valid = 1'b0;
    bus.pd_pc    = 32'h0;
    bus.pd_inst  = 32'h0;
    bus.pd_bd    = 1'b0;
    bus.pd_jump  = 1'b0;
    bus.id_stall = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_ready", 64'(bus.pd_ready), 64'd1);

    // 1: reset with three entries queued
    push(32'h10);
    push(32'h14);
    push(32'h18);
    chk("t1_count3", 64'(bus.count), 64'd3);
    chk("t1_head", 64'(bus.id_pc), 64'h10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t1_count", 64'(bus.count), 64'd0);
    chk("t1_valid", 64'(bus.id_valid), 64'd0);
    chk("t1_pc", 64'(bus.id_pc), 64'd0);
    chk("t1_ready", 64'(bus.pd_ready), 64'd1);

    // 2: fill to DEPTH, drop a fifth push, drain in order
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i));
    chk("t2_count", 64'(bus.count), 64'd4);
    chk("t2_ready", 64'(bus.pd_ready), 64'd0);
    push(32'h110);
    chk("t2_drop", 64'(bus.count), 64'd4);
    bus.id_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", 64'(bus.id_valid), 64'd1);
      chk("t2_order", 64'(bus.id_pc), 64'(32'h100 + 32'(4 * i)));
      chk("t2_inst", 64'(bus.id_inst), 64'((32'h100 + 32'(4 * i)) ^ 32'hA5A5_0000));
      tick();
    end
    chk("t2_empty", 64'(bus.count), 64'd0);
    chk("t2_novalid", 64'(bus.id_valid), 64'd0);

    // 3: steady push+pop at count 2 across pointer wrap
    bus.id_stall = 1'b1;
    push(32'h300);
    push(32'h304);
    bus.id_stall = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.pd_valid = 1'b1;
      bus.pd_pc    = 32'h308 + 32'(4 * k);
      bus.pd_inst  = 32'h0;
      chk("t3_head", 64'(bus.id_pc), 64'(32'h300 + 32'(4 * k)));
      tick();
      chk("t3_count", 64'(bus.count), 64'd2);
    end
    bus.pd_valid = 1'b0;
    for (int k = 9; k < 11; k++) begin
      chk("t3_drain", 64'(bus.id_pc), 64'(32'h300 + 32'(4 * k)));
      tick();
    end
    chk("t3_empty", 64'(bus.count), 64'd0);

    // 4: lone jump is held until its delay slot is queued
    bus.pd_jump = 1'b1;
    bus.pd_valid = 1'b1;
    bus.pd_pc = 32'h200;
    bus.pd_inst = 32'hAAAA;
    tick();
    bus.pd_valid = 1'b0;
    bus.pd_jump = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t4_hold", 64'(bus.id_valid), 64'd0);
      chk("t4_mask", 64'(bus.id_pc), 64'd0);
      chk("t4_count", 64'(bus.count), 64'd1);
      tick();
    end
    bus.pd_bd = 1'b1;
    bus.pd_valid = 1'b1;
    bus.pd_pc = 32'h204;
    bus.pd_inst = 32'hBBBB;
    chk("t4_prepush", 64'(bus.id_valid), 64'd0);
    tick();
    bus.pd_valid = 1'b0;
    bus.pd_bd = 1'b0;
    chk("t4_valid", 64'(bus.id_valid), 64'd1);
    chk("t4_jpc", 64'(bus.id_pc), 64'h200);
    chk("t4_jflag", 64'(bus.id_jump), 64'd1);
    chk("t4_jinst", 64'(bus.id_inst), 64'hAAAA);
    chk("t4_jbd", 64'(bus.id_bd), 64'd0);
    tick();
    chk("t4_dpc", 64'(bus.id_pc), 64'h204);
    chk("t4_dbd", 64'(bus.id_bd), 64'd1);
    chk("t4_djump", 64'(bus.id_jump), 64'd0);
    tick();
    chk("t4_empty", 64'(bus.count), 64'd0);

    // 5: refresh discards queue and the same-cycle push
    bus.id_stall = 1'b1;
    push(32'h400);
    push(32'h404);
    push(32'h408);
    refresh = 1'b1;
    bus.pd_valid = 1'b1;
    bus.pd_pc = 32'h4FC;
    tick();
    refresh = 1'b0;
    bus.pd_valid = 1'b0;
    chk("t5_count", 64'(bus.count), 64'd0);
    chk("t5_valid", 64'(bus.id_valid), 64'd0);
    chk("t5_pc", 64'(bus.id_pc), 64'd0);
    push(32'h500);
    chk("t5_next", 64'(bus.id_pc), 64'h500);
    chk("t5_count1", 64'(bus.count), 64'd1);
    bus.id_stall = 1'b0;
    tick();
    chk("t5_empty", 64'(bus.count), 64'd0);

    // 6: pop while full; the offered push is rejected
    bus.id_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h600 + 32'(4 * i));
    chk("t6_full", 64'(bus.pd_ready), 64'd0);
    bus.id_stall = 1'b0;
    bus.pd_valid = 1'b1;
    bus.pd_pc = 32'h6F0;
    tick();
    bus.pd_valid = 1'b0;
    chk("t6_count", 64'(bus.count), 64'd3);
    for (int i = 1; i < 4; i++) begin
      chk("t6_order", 64'(bus.id_pc), 64'(32'h600 + 32'(4 * i)));
      tick();
    end
    chk("t6_empty", 64'(bus.count), 64'd0);
    chk("t6_novalid", 64'(bus.id_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
